// File: rtl/result_reader_if.sv
// Read-side bus of the result reader: RAM read port plus the valid/ready result stream.
// The reader uses the master view; the RAM and the downstream sink sit on the slave view.
interface result_reader_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output ram_re,
    output ram_addr,
    input  ram_rdata,
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  ram_re,
    input  ram_addr,
    output ram_rdata,
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/result_reader.sv
// Streams the result RAM out in address order through a 2-entry output FIFO with
// full valid/ready backpressure, and keeps a running checksum of the accepted words.
module result_reader #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int SUM_W  = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  result_reader_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ALL_OUT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic              busy_r;
  logic              done_r;
  logic [SUM_W-1:0]  checksum_r;

  logic              rd_pend_r;
  logic [1:0]        occ_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] tail_r;
  logic              valid_r;

  logic              xfer_s;
  logic              issue_s;
  logic [2:0]        load_s;
  logic [CNT_W-1:0]  out_cnt_nxt_s;
  logic [SUM_W-1:0]  checksum_nxt_s;

  // Read gating, transfer detection and next counter/checksum values.
  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what lets the stream sustain one word per cycle.
  always_comb begin
    xfer_s         = valid_r & bus.dout_ready;
    load_s         = {1'b0, occ_r} + {2'b00, rd_pend_r} - {2'b00, xfer_s};
    issue_s        = 1'b0;
    out_cnt_nxt_s  = out_cnt_r;
    checksum_nxt_s = checksum_r;
    if ((state_r == ST_READ) && (load_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (xfer_s) begin
      out_cnt_nxt_s  = out_cnt_r + CNT_ONE;
      checksum_nxt_s = checksum_r + SUM_W'(head_r);
    end else begin
      out_cnt_nxt_s  = out_cnt_r;
      checksum_nxt_s = checksum_r;
    end
  end

  assign bus.ram_re     = issue_s;
  assign bus.ram_addr   = issue_s ? rd_cnt_r[ADDR_W-1:0] : last_addr_r;
  assign bus.dout       = head_r;
  assign bus.dout_valid = valid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign checksum       = checksum_r;

  // Run control FSM: counters, checksum, busy and the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      rd_cnt_r    <= '0;
      out_cnt_r   <= '0;
      last_addr_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      checksum_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_READ;
            busy_r     <= 1'b1;
            rd_cnt_r   <= '0;
            out_cnt_r  <= '0;
            checksum_r <= '0;
          end
        end
        ST_READ: begin
          out_cnt_r  <= out_cnt_nxt_s;
          checksum_r <= checksum_nxt_s;
          if (issue_s) begin
            rd_cnt_r    <= rd_cnt_r + CNT_ONE;
            last_addr_r <= rd_cnt_r[ADDR_W-1:0];
            if (rd_cnt_r == LAST_RD) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          out_cnt_r  <= out_cnt_nxt_s;
          checksum_r <= checksum_nxt_s;
          if (out_cnt_nxt_s == ALL_OUT) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO: head_r is the visible dout, tail_r the second slot.
  // Capture with two words already held is excluded by the read gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r <= 1'b0;
      occ_r     <= 2'd0;
      head_r    <= '0;
      tail_r    <= '0;
      valid_r   <= 1'b0;
    end else begin
      rd_pend_r <= issue_s;
      case ({rd_pend_r, xfer_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r  <= bus.ram_rdata;
            occ_r   <= 2'd1;
            valid_r <= 1'b1;
          end else begin
            tail_r <= bus.ram_rdata;
            occ_r  <= 2'd2;
          end
        end
        2'b01: begin
          head_r  <= tail_r;
          occ_r   <= occ_r - 2'd1;
          valid_r <= (occ_r != 2'd1);
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= bus.ram_rdata;
          end else begin
            head_r <= tail_r;
            tail_r <= bus.ram_rdata;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: RAM model, scoreboard queue filled at each accepted
// start and drained on every dout transfer, plus per-cycle latency and stall checks.
module tb_result_reader;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int SUM_W  = 22;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] checksum;

  result_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  result_reader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];

  // RAM model: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int rd_total = 0;
  int outstanding = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_q [$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;

  logic              s_ram_re, s_valid, s_done, s_busy;
  logic [DATA_W-1:0] s_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and score at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [DATA_W-1:0] w;
    @(negedge clk);
    s_ram_re = bus.ram_re;
    s_valid  = bus.dout_valid;
    s_done   = done;
    s_busy   = busy;
    s_dout   = bus.dout;
    if (!reset_n) begin
      exp_q.delete();
      outstanding = 0;
      exp_addr    = '0;
      prev_stall  = 1'b0;
    end else begin
      chk("reads_plus_occupancy_le2", outstanding <= 2, 1);
      if (prev_stall) begin
        chk("stall_valid", s_valid, 1);
        chk("stall_dout", s_dout, prev_dout);
      end
      if (s_ram_re) begin
        chk("ram_addr", bus.ram_addr, exp_addr);
        exp_addr++;
        outstanding++;
        rd_total++;
      end
      if (s_done) begin
        done_cnt++;
        chk("busy_low_in_done", s_busy, 0);
      end
      if (s_valid && bus.dout_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("dout_word", s_dout, w);
        end
        outstanding--;
        xfer_cnt++;
      end
      prev_stall = s_valid && !bus.dout_ready;
      prev_dout  = s_dout;
      if (start && !s_busy && !s_done) begin
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(mem[k]);
        exp_addr = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
  task automatic run_until_done(input int mode, input int start_at, input int reset_at,
                                input int max_cyc);
    int  d0;
    int  x0;
    bit  pulsed;
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulsed = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      case (mode)
        1:       bus.dout_ready = ((i % 4) == 0) || ((i % 4) == 3);
        default: bus.dout_ready = 1'b1;
      endcase
      if (start_at > 0 && !pulsed && (xfer_cnt - x0) == start_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (reset_at > 0 && (xfer_cnt - x0) == reset_at) begin
        start   = 1'b0;
        reset_n = 1'b0;
        return;
      end
      tick();
      if (done_cnt != d0) break;
    end
    start = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(k + 1);
  endtask

  initial begin
    int d0;
    int x0;
    int r0;
    reset_n = 1'b0;
    start   = 1'b0;
    bus.dout_ready = 1'b0;
    load_ramp();
    tick();
    tick();
    chk("rst_ram_re", bus.ram_re, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    reset_n = 1'b1;
    tick();

    // Full-rate run with exact cycle-by-cycle timing.
    bus.dout_ready = 1'b1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    for (int c = 1; c <= 19; c++) begin
      tick();
      chk("t1_ram_re", s_ram_re, (c <= 16));
      chk("t1_dout_valid", s_valid, (c >= 3 && c <= 18));
      chk("t1_done", s_done, (c == 19));
      chk("t1_busy", s_busy, (c <= 18));
    end
    chk("t1_checksum", checksum, 136);
    chk("t1_words", xfer_cnt - x0, 16);
    chk("t1_done_count", done_cnt - d0, 1);

    // Ready toggling 1,0,0,1.
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    run_until_done(1, 0, 0, 300);
    chk("t2_done_count", done_cnt - d0, 1);
    chk("t2_words", xfer_cnt - x0, 16);
    chk("t2_checksum", checksum, 136);
    chk("t2_queue_empty", exp_q.size(), 0);

    // All-ones data: widest checksum.
    for (int k = 0; k < DEPTH; k++) mem[k] = 18'h3FFFF;
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    run_until_done(0, 0, 0, 200);
    chk("t3_done_count", done_cnt - d0, 1);
    chk("t3_words", xfer_cnt - x0, 16);
    chk("t3_checksum", checksum, 22'h3FFFF0);

    // Start again after the 5th transfer: must be ignored.
    load_ramp();
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    run_until_done(0, 5, 0, 200);
    repeat (4) tick();
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_words", xfer_cnt - x0, 16);
    chk("t4_busy_after", busy, 0);
    chk("t4_checksum", checksum, 136);

    // Reset after the 8th transfer, then a clean run.
    d0 = done_cnt;
    pulse_start();
    run_until_done(0, 0, 8, 200);
    #1;
    chk("t5_rst_ram_re", bus.ram_re, 0);
    chk("t5_rst_ram_addr", bus.ram_addr, 0);
    chk("t5_rst_dout", bus.dout, 0);
    chk("t5_rst_dout_valid", bus.dout_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_checksum", checksum, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    run_until_done(0, 0, 0, 200);
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_words", xfer_cnt - x0, 16);
    chk("t5_checksum", checksum, 136);

    // Sink stalled for 20 cycles from start.
    bus.dout_ready = 1'b0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    r0 = rd_total;
    pulse_start();
    repeat (20) tick();
    chk("t6_reads_while_stalled", rd_total - r0, 2);
    chk("t6_dout_held", s_dout, 1);
    chk("t6_valid_held", s_valid, 1);
    run_until_done(0, 0, 0, 200);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_words", xfer_cnt - x0, 16);
    chk("t6_checksum", checksum, 136);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
